// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-port SRAM; clears the array after reset.
// Define ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module sram_port_arbiter #(
    parameter int SRAM_BIT = 160,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [SRAM_BIT-1:0] wdata0,
    input  logic [SRAM_BIT-1:0] wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                rvalid0,
    output logic                rvalid1,
    output logic [SRAM_BIT-1:0] rdata,
    output logic                init_done,
    output logic                sram_cen,
    output logic                sram_wen,
    output logic [ADDR_W-1:0]   sram_a,
    output logic [SRAM_BIT-1:0] sram_d,
    input  logic [SRAM_BIT-1:0] sram_q
);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              rv0_q;
    logic              rv1_q;
    logic              pick1;

`ifdef ARB_FIXED_PRIO_EN
    assign pick1 = req1 & ~req0;
`else
    logic ptr;

    // ptr=1 means port 1 is preferred on the next contention
    assign pick1 = req1 & (~req0 | ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (gnt0 | gnt1) begin
            ptr <= gnt0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                cnt <= cnt + ADDR_W'(1);
            end
            rv0_q <= gnt0 & ~we0;
            rv1_q <= gnt1 & ~we1;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_a    = '0;
        sram_d    = '0;
        if (!reset) begin
            unique case (state)
                INIT: begin
                    sram_cen = 1'b0;
                    sram_wen = 1'b0;
                    sram_a   = cnt;
                    if (cnt == '1) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    gnt0 = req0 & ~pick1;
                    gnt1 = pick1;
                    if (req0 | req1) begin
                        sram_cen = 1'b0;
                        sram_wen = pick1 ? ~we1 : ~we0;
                        sram_a   = pick1 ? addr1 : addr0;
                        sram_d   = pick1 ? wdata1 : wdata0;
                    end
                end
                default: ;
            endcase
        end
    end

    // a reset landing on the response cycle suppresses that response
    assign rvalid0   = rv0_q & ~reset;
    assign rvalid1   = rv1_q & ~reset;
    assign rdata     = sram_q;
    assign init_done = (state == RUN);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural 1-cycle SRAM.
// Grant pattern expectations follow ARB_FIXED_PRIO_EN when it is defined.
module tb_sram_port_arbiter;

    localparam int W  = 160;
    localparam int AW = 3;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit RR = 1'b0;
`else
    localparam bit RR = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [W-1:0]  wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, init_done;
    logic          sram_cen, sram_wen;
    logic [AW-1:0] sram_a;
    logic [W-1:0]  sram_d, sram_q, rdata;

    always #5 clk = ~clk;

    sram_port_arbiter #(.SRAM_BIT(W), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .init_done(init_done),
        .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    logic [W-1:0] mem [8];

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q <= mem[sram_a];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         port;
        logic [W-1:0] data;
        int           when;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string n, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic push(input logic p, input logic [W-1:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        e.when = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic go(input logic r0, input logic w0,
                      input logic [AW-1:0] a0, input logic [W-1:0] d0,
                      input logic r1, input logic w1,
                      input logic [AW-1:0] a1, input logic [W-1:0] d1);
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
    endtask

    // response monitor: every rvalid must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rvalid0 || rvalid1) begin
            chk("rvalid_excl", W'(rvalid0 & rvalid1), W'(0));
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rvalid: got rv0=%0b rv1=%0b want none",
                         rvalid0, rvalid1);
            end else begin
                e = sb.pop_front();
                chk("rvalid_port", W'(rvalid1), W'(e.port));
                chk("rvalid_cycle", W'(cyc), W'(e.when));
                chk("rdata", rdata, e.data);
            end
        end
    end

    localparam logic [W-1:0] DA5 = W'('hA5);
    localparam logic [W-1:0] D5  = {5{32'h1234_5678}};

    initial begin
        logic e1;
        for (int i = 0; i < 8; i++) mem[i] = {5{32'hBAD0_0000 + i}};
        reset = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cen", W'(sram_cen), W'(1));
        chk("rst_gnt", W'({gnt1, gnt0}), W'(0));
        chk("rst_done", W'(init_done), W'(0));
        chk("rst_rvalid", W'({rvalid1, rvalid0}), W'(0));

        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("init1_a", W'(sram_a), W'(i));
            if (i < 4) begin
                @(negedge clk);
                #1;
            end
        end
        reset = 1'b1;
        #1;
        chk("midinit_rst_cen", W'(sram_cen), W'(1));
        chk("midinit_rst_gnt", W'({gnt1, gnt0}), W'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("init_a", W'(sram_a), W'(i));
            chk("init_cen", W'(sram_cen), W'(0));
            chk("init_wen", W'(sram_wen), W'(0));
            chk("init_d", sram_d, W'(0));
            chk("init_gnt", W'({gnt1, gnt0}), W'(0));
            chk("init_done_lo", W'(init_done), W'(0));
            if (i == 7) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        chk("init_done_hi", W'(init_done), W'(1));
        chk("idle_cen", W'(sram_cen), W'(1));
        chk("idle_wen", W'(sram_wen), W'(1));
        chk("idle_gnt", W'({gnt1, gnt0}), W'(0));

        go(1, 0, 2, '0, 0, 0, 0, '0);
        chk("rd_clr_gnt", W'({gnt1, gnt0}), W'(2'b01));
        chk("rd_clr_wen", W'(sram_wen), W'(1));
        chk("rd_clr_a", W'(sram_a), W'(2));
        push(1'b0, W'(0));

        go(1, 1, 3, DA5, 0, 0, 0, '0);
        chk("wr0_gnt", W'({gnt1, gnt0}), W'(2'b01));
        chk("wr0_cen", W'(sram_cen), W'(0));
        chk("wr0_wen", W'(sram_wen), W'(0));
        chk("wr0_a", W'(sram_a), W'(3));
        chk("wr0_d", sram_d, DA5);

        go(1, 0, 3, '0, 0, 0, 0, '0);
        chk("rd0_gnt", W'({gnt1, gnt0}), W'(2'b01));
        chk("rd0_wen", W'(sram_wen), W'(1));
        push(1'b0, DA5);

        go(0, 0, 0, '0, 1, 1, 5, D5);
        chk("wr1_gnt", W'({gnt1, gnt0}), W'(2'b10));
        chk("wr1_a", W'(sram_a), W'(5));
        chk("wr1_d", sram_d, D5);

        for (int k = 0; k < 4; k++) begin
            go(1, 0, 3, '0, 1, 0, 5, '0);
            e1 = RR && (k % 2 == 1);
            chk("both_gnt", W'({gnt1, gnt0}), W'({e1, ~e1}));
            chk("both_a", W'(sram_a), e1 ? W'(5) : W'(3));
            push(e1, e1 ? D5 : DA5);
        end

        go(0, 0, 0, '0, 0, 0, 0, '0);
        chk("idle2_cen", W'(sram_cen), W'(1));
        chk("idle2_gnt", W'({gnt1, gnt0}), W'(0));

        go(0, 0, 0, '0, 1, 0, 5, '0);
        chk("rd1_gnt", W'({gnt1, gnt0}), W'(2'b10));

        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_rv1_a", W'(rvalid1), W'(0));
        chk("rst_gnt2", W'({gnt1, gnt0}), W'(0));
        chk("rst_cen2", W'(sram_cen), W'(1));
        @(negedge clk);
        #1;
        chk("rst_rv1_b", W'(rvalid1), W'(0));
        chk("rst_done2", W'(init_done), W'(0));
        reset = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("sb_empty", W'(sb.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter SRAM_BIT, default 160, the data word width.
REQ-002 SHALL have parameter ADDR_W, default 3, the address width (2^ADDR_W = 8 entries).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have ports req0/req1, input, 1 each, requester access request.
REQ-006 SHALL have ports we0/we1, input, 1 each, 1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1, input, ADDR_W each, request address.
REQ-008 SHALL have ports wdata0/wdata1, input, SRAM_BIT each, write data.
REQ-009 SHALL have ports gnt0/gnt1, output, 1 each, combinational grant; the request is accepted in the cycle where req and gnt are both high.
REQ-010 SHALL have ports rvalid0/rvalid1, output, 1 each, registered read-response valid.
REQ-011 SHALL have port rdata, output, SRAM_BIT, the read data, driven directly from sram_q.
REQ-012 SHALL have port init_done, output, 1, high once the clear sequence completes.
REQ-013 SHALL have SRAM-side ports sram_cen (output, 1, active-low enable), sram_wen (output, 1, 0 = write), sram_a (output, ADDR_W), sram_d (output, SRAM_BIT) and sram_q (input, SRAM_BIT); the SRAM has 1-cycle registered read latency.

Function
REQ-014 The FSM SHALL have states INIT and RUN.
REQ-015 In INIT, a 3-bit counter SHALL step 0..7, issuing one write per cycle with sram_cen=0, sram_wen=0, sram_a=counter and sram_d=0, while gnt0 and gnt1 are held at 0.
REQ-016 When the counter reaches 7, the FSM SHALL enter RUN on the next edge and set init_done=1; INIT lasts exactly 8 cycles.
REQ-017 In RUN, if no request is pending, the block SHALL drive sram_cen=1, sram_wen=1, and gnt0 = gnt1 = 0.
REQ-018 In RUN, at most one grant SHALL be asserted per cycle, and only to a requester whose req is high.
REQ-019 The granted port's we, addr and wdata SHALL drive the SRAM in the same cycle, with sram_cen=0 and sram_wen=~we.
REQ-020 On a simultaneous request from both ports, the winner SHALL be selected by a 1-bit round-robin pointer (0 = port 0 preferred).
REQ-021 The pointer SHALL update after each grant to prefer the non-granted port, and SHALL be unchanged on idle cycles.
REQ-022 A single requester SHALL be granted immediately, regardless of the pointer.
REQ-023 A read granted in cycle t SHALL assert the granted port's rvalid during cycle t+1 only, with rdata=sram_q valid in that cycle.
REQ-024 Back-to-back reads SHALL yield rvalid in consecutive cycles, at full throughput of 1 access per cycle.
REQ-025 A write SHALL produce no rvalid.
REQ-026 A read of an address written in the preceding cycle SHALL return the new data, with no forwarding logic required.
REQ-027 rvalid0 and rvalid1 SHALL never be high in the same cycle.

Reset
REQ-028 While reset=1 at an edge, the block SHALL set state=INIT, counter=0, pointer=0, rvalid0=rvalid1=0 and init_done=0.
REQ-029 While reset=1, sram_cen SHALL be 1 and gnt0 = gnt1 = 0.
REQ-030 Reset asserted mid-INIT SHALL restart the clear sequence at address 0.
REQ-031 Reset asserted in the cycle after a read grant SHALL clear the pending rvalid at that edge, so no response is emitted.
REQ-032 SRAM contents SHALL not be read during INIT.

Configuration
REQ-033 With macro ARB_FIXED_PRIO_EN defined, port 0 SHALL always win a simultaneous request and the pointer logic SHALL be absent.
REQ-034 Without ARB_FIXED_PRIO_EN, the block SHALL use round-robin arbitration as specified in REQ-020 to REQ-022.
REQ-035 All other behaviour SHALL be identical with and without ARB_FIXED_PRIO_EN.

Verification
REQ-036 Release reset and hold the requesters at 1 -> sram_a=0..7 with sram_wen=0 and sram_d=0 for 8 cycles, gnt=0 throughout, init_done=1 in cycle 9.
REQ-037 After init, port 0 writes 0xA5 to addr 3, then reads addr 3 in the next cycle -> rvalid0=1 one cycle after the read grant, rdata=0xA5.
REQ-038 req0 and req1 reads held high for 4 cycles (round-robin build) -> grants alternate 0,1,0,1 and rvalid alternates 0,1,0,1, each delayed by one cycle.
REQ-039 Same stimulus as REQ-038 with ARB_FIXED_PRIO_EN defined -> gnt0 high all 4 cycles and gnt1 never high.
REQ-040 Reset asserted at INIT counter=4 -> sequence restarts at sram_a=0 and init_done stays 0 for 8 more cycles.
REQ-041 Port 1 read granted, then reset asserted in the next cycle -> rvalid1 stays 0.
